led_seq_master: RTL and testbench

Parametrised LED pattern sequencer driving NUM_LEDS outputs from a single system clock. A mode-selected prescaler generates clock-enable step ticks rather than a derived clock; a run/pause/idle state machine advances one of four selectable patterns (scan, bounce, fill, blink). It sits directly behind the board LED pins and is controlled by the front-panel start/idle/stop pulses and the mode/pattern switches.

---
 rtl/led_seq_if.sv | 24 ++
 rtl/led_seq_master.sv | 168 ++++++++++++++++
 tb/tb_led_seq_master.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/led_seq_if.sv
// Control and status bundle between the front panel / board pins and the LED sequencer.
interface led_seq_if #(
    parameter int NUM_LEDS = 16
);
    logic                start;
    logic                stop;
    logic                idle;
    logic [1:0]          mode;
    logic [1:0]          pattern;
    logic [NUM_LEDS-1:0] led;
    logic                busy;
    logic                step;
    logic                wrap;

    modport master (
        output start, stop, idle, mode, pattern,
        input  led, busy, step, wrap
    );

    modport slave (
        input  start, stop, idle, mode, pattern,
        output led, busy, step, wrap
    );
endinterface

// File: rtl/led_seq_master.sv
// LED pattern sequencer: clock-enable prescaler plus IDLE/RUN/PAUSE FSM stepping
// scan, bounce, fill or blink patterns across NUM_LEDS registered outputs.
module led_seq_master #(
    parameter int NUM_LEDS   = 16,
    parameter int PRESC_W    = 24,
    parameter int LIMIT_LOW  = 2**22,
    parameter int LIMIT_NORM = 2**21,
    parameter int LIMIT_HIGH = 2**20
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        mini_rst,
    led_seq_if.slave    bus
);

    localparam int POS_W = $clog2(NUM_LEDS + 1);

    typedef logic [POS_W-1:0]   pos_t;
    typedef logic [PRESC_W-1:0] presc_t;
    typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_RUN = 2'b01, ST_PAUSE = 2'b10} state_t;

    localparam pos_t   POS_ZERO  = {POS_W{1'b0}};
    localparam pos_t   POS_ONE   = {{(POS_W-1){1'b0}}, 1'b1};
    localparam pos_t   POS_TOP   = pos_t'(NUM_LEDS - 1);
    localparam pos_t   POS_FULL  = pos_t'(NUM_LEDS);
    localparam presc_t PRESC_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};
    localparam logic   DIR_UP    = 1'b0;
    localparam logic   DIR_DN    = 1'b1;

    // LED image for a given pattern at a given position.
    function automatic logic [NUM_LEDS-1:0] pattern_led(input logic [1:0] pat, input pos_t pos);
        logic [NUM_LEDS:0] fill_v;
        fill_v = ({{NUM_LEDS{1'b0}}, 1'b1} << pos) - {{NUM_LEDS{1'b0}}, 1'b1};
        case (pat)
            2'b00, 2'b01: pattern_led = {{(NUM_LEDS-1){1'b0}}, 1'b1} << pos;
            2'b10:        pattern_led = fill_v[NUM_LEDS-1:0];
            2'b11:        pattern_led = (pos == POS_ONE) ? {NUM_LEDS{1'b1}} : {NUM_LEDS{1'b0}};
            default:      pattern_led = {NUM_LEDS{1'b0}};
        endcase
    endfunction

    state_t              state_r, state_nxt_s;
    presc_t              presc_r, presc_nxt_s, lim_m1_s;
    pos_t                pos_r, pos_nxt_s;
    logic                dir_r, dir_nxt_s;
    logic [1:0]          mode_prev_r, pat_prev_r;
    logic [NUM_LEDS-1:0] led_r;
    logic                busy_r, step_r, wrap_r;
    logic                tick_s, wrap_s, adv_s, mode_chg_s, pat_chg_s;

    assign mode_chg_s = (bus.mode != mode_prev_r);
    assign pat_chg_s  = (bus.pattern != pat_prev_r);
    assign adv_s      = (state_r != ST_IDLE) && (state_nxt_s == ST_RUN);

    // Step period selection; mode 00 never counts, so its value is don't-care.
    always_comb begin
        case (bus.mode)
            2'b01:   lim_m1_s = presc_t'(LIMIT_LOW - 1);
            2'b10:   lim_m1_s = presc_t'(LIMIT_NORM - 1);
            2'b11:   lim_m1_s = presc_t'(LIMIT_HIGH - 1);
            default: lim_m1_s = presc_t'(LIMIT_NORM - 1);
        endcase
    end

    // Next-state logic: stop beats mini_rst, which holds the state.
    always_comb begin
        state_nxt_s = state_r;
        if (bus.stop) begin
            state_nxt_s = ST_IDLE;
        end else if (mini_rst) begin
            state_nxt_s = state_r;
        end else begin
            case (state_r)
                ST_IDLE:  state_nxt_s = (bus.start && bus.mode != 2'b00) ? ST_RUN : ST_IDLE;
                ST_RUN:   state_nxt_s = (bus.idle || bus.mode == 2'b00) ? ST_PAUSE : ST_RUN;
                ST_PAUSE: state_nxt_s = (!bus.idle && bus.mode != 2'b00) ? ST_RUN : ST_PAUSE;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Prescaler and pattern position update; clears suppress the tick in the same cycle.
    always_comb begin
        presc_nxt_s = presc_r;
        pos_nxt_s   = pos_r;
        dir_nxt_s   = dir_r;
        tick_s      = 1'b0;
        wrap_s      = 1'b0;
        if (state_nxt_s == ST_IDLE || mini_rst || pat_chg_s) begin
            presc_nxt_s = {PRESC_W{1'b0}};
            pos_nxt_s   = POS_ZERO;
            dir_nxt_s   = DIR_UP;
        end else if (mode_chg_s) begin
            presc_nxt_s = {PRESC_W{1'b0}};
        end else if (adv_s) begin
            if (presc_r >= lim_m1_s) begin
                presc_nxt_s = {PRESC_W{1'b0}};
                tick_s      = 1'b1;
                case (bus.pattern)
                    2'b00: begin
                        pos_nxt_s = (pos_r >= POS_TOP) ? POS_ZERO : pos_r + POS_ONE;
                        wrap_s    = (pos_r >= POS_TOP);
                    end
                    2'b01: begin
                        if (dir_r == DIR_UP) begin
                            pos_nxt_s = pos_r + POS_ONE;
                            dir_nxt_s = (pos_r + POS_ONE >= POS_TOP) ? DIR_DN : DIR_UP;
                        end else begin
                            pos_nxt_s = (pos_r <= POS_ONE) ? POS_ZERO : pos_r - POS_ONE;
                            dir_nxt_s = (pos_r <= POS_ONE) ? DIR_UP : DIR_DN;
                            wrap_s    = (pos_r <= POS_ONE);
                        end
                    end
                    2'b10: begin
                        pos_nxt_s = (pos_r >= POS_FULL) ? POS_ZERO : pos_r + POS_ONE;
                        wrap_s    = (pos_r >= POS_FULL);
                    end
                    2'b11: begin
                        pos_nxt_s = (pos_r == POS_ONE) ? POS_ZERO : POS_ONE;
                        wrap_s    = (pos_r == POS_ONE);
                    end
                    default: begin
                        pos_nxt_s = POS_ZERO;
                        dir_nxt_s = DIR_UP;
                    end
                endcase
            end else begin
                presc_nxt_s = presc_r + PRESC_ONE;
            end
        end else begin
            presc_nxt_s = presc_r;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_r     <= ST_IDLE;
            presc_r     <= {PRESC_W{1'b0}};
            pos_r       <= POS_ZERO;
            dir_r       <= DIR_UP;
            mode_prev_r <= 2'b00;
            pat_prev_r  <= 2'b00;
            led_r       <= {NUM_LEDS{1'b0}};
            busy_r      <= 1'b0;
            step_r      <= 1'b0;
            wrap_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            presc_r     <= presc_nxt_s;
            pos_r       <= pos_nxt_s;
            dir_r       <= dir_nxt_s;
            mode_prev_r <= bus.mode;
            pat_prev_r  <= bus.pattern;
            led_r       <= (state_nxt_s == ST_IDLE) ? {NUM_LEDS{1'b0}}
                                                    : pattern_led(bus.pattern, pos_nxt_s);
            busy_r      <= (state_nxt_s != ST_IDLE);
            step_r      <= tick_s;
            wrap_r      <= wrap_s;
        end
    end

    assign bus.led  = led_r;
    assign bus.busy = busy_r;
    assign bus.step = step_r;
    assign bus.wrap = wrap_r;

endmodule

// File: tb/tb_led_seq_master.sv
// Directed bench for led_seq_master: NUM_LEDS=8, step periods 8/4/2 clocks.
module tb_led_seq_master;

    logic sys_clk  = 1'b0;
    logic sys_rst  = 1'b0;
    logic mini_rst = 1'b0;
    int   checks   = 0;
    int   errors   = 0;

    led_seq_if #(.NUM_LEDS(8)) bus ();

    led_seq_master #(
        .NUM_LEDS(8), .PRESC_W(24), .LIMIT_LOW(8), .LIMIT_NORM(4), .LIMIT_HIGH(2)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .mini_rst (mini_rst),
        .bus      (bus)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] led, input logic busy,
                           input logic step, input logic wrap);
        chk({tag, ".led"},  {24'd0, bus.led}, {24'd0, led});
        chk({tag, ".busy"}, {31'd0, bus.busy}, {31'd0, busy});
        chk({tag, ".step"}, {31'd0, bus.step}, {31'd0, step});
        chk({tag, ".wrap"}, {31'd0, bus.wrap}, {31'd0, wrap});
    endtask

    initial begin
        logic [7:0] e;
        logic [8:0] f;
        int         p;
        bus.start = 1'b0; bus.stop = 1'b0; bus.idle = 1'b0;
        bus.mode = 2'b10; bus.pattern = 2'b00;

        cyc(3);
        chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        sys_rst = 1'b1;
        cyc(2);
        chk_out("idle_after_reset", 8'h00, 1'b0, 1'b0, 1'b0);

        // Scan at 4 clocks per step
        bus.start = 1'b1; cyc(1); bus.start = 1'b0;
        chk_out("scan_start", 8'h01, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            cyc(3);
            chk_out("scan_hold", (k == 1) ? 8'h01 : (8'h01 << ((k - 1) % 8)), 1'b1, 1'b0, 1'b0);
            cyc(1);
            e = 8'h01 << (k % 8);
            chk_out("scan_step", e, 1'b1, 1'b1, (k == 8));
        end
        cyc(12);
        chk_out("scan_at_08", 8'h08, 1'b1, 1'b1, 1'b0);

        // Pause for 20 cycles two clocks into the period
        cyc(2);
        bus.idle = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            chk_out("paused", 8'h08, 1'b1, 1'b0, 1'b0);
        end
        bus.idle = 1'b0;
        cyc(1);
        chk_out("resume_hold", 8'h08, 1'b1, 1'b0, 1'b0);
        cyc(1);
        chk_out("resume_step", 8'h10, 1'b1, 1'b1, 1'b0);

        // mini_rst coincident with a tick
        cyc(3);
        mini_rst = 1'b1; cyc(1); mini_rst = 1'b0;
        chk_out("mini_rst", 8'h01, 1'b1, 1'b0, 1'b0);
        cyc(3);
        chk_out("mini_rst_hold", 8'h01, 1'b1, 1'b0, 1'b0);
        cyc(1);
        chk_out("mini_rst_step", 8'h02, 1'b1, 1'b1, 1'b0);

        // stop coincident with a tick, then start refused in mode 00
        cyc(3);
        bus.stop = 1'b1; cyc(1); bus.stop = 1'b0;
        chk_out("stop_on_tick", 8'h00, 1'b0, 1'b0, 1'b0);
        bus.mode = 2'b00; cyc(1);
        bus.start = 1'b1; cyc(1); bus.start = 1'b0;
        chk_out("start_mode0", 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(2);
        chk_out("start_mode0_later", 8'h00, 1'b0, 1'b0, 1'b0);

        // Bounce at 2 clocks per step
        bus.mode = 2'b11; bus.pattern = 2'b01; cyc(2);
        bus.start = 1'b1; cyc(1); bus.start = 1'b0;
        chk_out("bounce_start", 8'h01, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            cyc(1);
            chk({"bounce_gap.step"}, {31'd0, bus.step}, 32'd0);
            cyc(1);
            p = ((k % 14) <= 7) ? (k % 14) : (14 - (k % 14));
            e = 8'h01 << p;
            chk_out("bounce_step", e, 1'b1, 1'b1, ((k % 14) == 0));
        end

        // Switch to fill mid-run: position clears, no wrap
        bus.pattern = 2'b10; cyc(1);
        chk_out("fill_switch", 8'h00, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            cyc(2);
            p = k % 9;
            f = (9'd1 << p) - 9'd1;
            chk_out("fill_step", f[7:0], 1'b1, 1'b1, (k == 9));
        end

        // Switch to blink mid-fill
        bus.pattern = 2'b11; cyc(1);
        chk_out("blink_switch", 8'h00, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            cyc(2);
            chk_out("blink_step", (k % 2 == 1) ? 8'hFF : 8'h00, 1'b1, 1'b1, (k % 2 == 0));
        end
        cyc(1);
        chk_out("blink_before_rst", 8'hFF, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset between clock edges
        #2 sys_rst = 1'b0;
        #1 chk_out("async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge sys_clk);
        sys_rst = 1'b1; bus.pattern = 2'b00; bus.mode = 2'b10;
        cyc(2);
        bus.start = 1'b1; cyc(1); bus.start = 1'b0;
        chk_out("restart", 8'h01, 1'b1, 1'b0, 1'b0);
        cyc(4);
        chk_out("restart_step", 8'h02, 1'b1, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
